// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the hazard scoreboard.
// Holds the register-index width, the architectural register count,
// the pending-counter width and the counter operation decode helper.
package hazard_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;
    localparam int CNT_W     = 2;

    localparam logic [CNT_W-1:0] CNT_ZERO = 2'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 2'd1;
    localparam logic [CNT_W-1:0] CNT_MAX  = 2'd3;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    typedef enum logic [1:0] {
        CNT_OP_HOLD = 2'd0,
        CNT_OP_UP   = 2'd1,
        CNT_OP_DOWN = 2'd2
    } cnt_op_e;

    // An issue and a retire of the same register in one cycle cancel out.
    function automatic cnt_op_e cnt_op(input logic hold, input logic inc, input logic dec);
        cnt_op_e op;
        if (hold) begin
            op = CNT_OP_HOLD;
        end else if (inc && !dec) begin
            op = CNT_OP_UP;
        end else if (dec && !inc) begin
            op = CNT_OP_DOWN;
        end else begin
            op = CNT_OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_pending_counter.sv
// pending_counter: saturating up/down count of writes in flight to one register.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   hold_i         pipeline frozen: count holds
//   inc_i, dec_i   issue / retire of a write to this register
//   nz_o           count is non-zero
//   full_o         count is at its maximum
//   underflow_o    retire seen while count is zero (count stays at zero)
module pending_counter
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic hold_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic nz_o,
    output logic full_o,
    output logic underflow_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic underflow_s;

    // Next count: saturate at both ends, flag a retire with nothing pending.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_s = 1'b0;
        case (cnt_op(hold_i, inc_i, dec_i))
            CNT_OP_UP: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            CNT_OP_DOWN: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    underflow_s = 1'b1;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz_o        = (cnt_q != CNT_ZERO);
    assign full_o      = (cnt_q == CNT_MAX);
    assign underflow_o = underflow_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks writes in flight per register and raises a
// stall when the ID-stage instruction may not issue.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   forwardEn                1: only load-use stalls; 0: stall on any pending source
//   freeze                   whole pipeline held, all state holds
//   flush                    ID-stage instruction squashed
//   issueValid/WbEn/MemRead  ID-stage instruction present / writes / is a load
//   issueDest, src1, src2    destination and source registers
//   hasSrc1, hasSrc2         sources actually read
//   wbEn, wbDest             write-back retire
//   hazard                   stall IF/ID, bubble into EXE (combinational)
//   busy                     some write is in flight
//   err                      sticky: retire with no matching issue
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 forwardEn,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 issueValid,
    input  logic                 issueWbEn,
    input  logic                 issueMemRead,
    input  logic [REG_IDX_W-1:0] issueDest,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 hasSrc1,
    input  logic                 hasSrc2,
    input  logic                 wbEn,
    input  logic [REG_IDX_W-1:0] wbDest,
    output logic                 hazard,
    output logic                 busy,
    output logic                 err
);

    logic [NUM_REGS-1:0] inc_s;
    logic [NUM_REGS-1:0] dec_s;
    logic [NUM_REGS-1:0] nz_s;
    logic [NUM_REGS-1:0] full_s;
    logic [NUM_REGS-1:0] underflow_s;

    logic     hazard_s;
    logic     accept_s;
    logic     data_haz_s;
    logic     load_use_s;

    logic     exe_load_valid_q;
    logic     exe_load_valid_d;
    reg_idx_t exe_load_dest_q;
    reg_idx_t exe_load_dest_d;
    logic     err_q;
    logic     err_d;

    // Stall decision: data hazard for the selected mode, or destination counter full.
    always_comb begin
        load_use_s = exe_load_valid_q &&
                     ((hasSrc1 && (src1 == exe_load_dest_q)) ||
                      (hasSrc2 && (src2 == exe_load_dest_q)));
        if (forwardEn) begin
            data_haz_s = load_use_s;
        end else begin
            data_haz_s = (hasSrc1 && nz_s[src1]) || (hasSrc2 && nz_s[src2]);
        end
        hazard_s = issueValid && (data_haz_s || (issueWbEn && full_s[issueDest]));
    end

    assign accept_s = issueValid && !hazard_s && !freeze && !flush;

    // One-hot issue and retire strobes per register.
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_s[r] = accept_s && issueWbEn && (issueDest == REG_IDX_W'(r));
            dec_s[r] = wbEn && !freeze && (wbDest == REG_IDX_W'(r));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
        pending_counter u_cnt (
            .clk         (clk),
            .rst_n       (rst),
            .hold_i      (freeze),
            .inc_i       (inc_s[g]),
            .dec_i       (dec_s[g]),
            .nz_o        (nz_s[g]),
            .full_o      (full_s[g]),
            .underflow_o (underflow_s[g])
        );
    end

    // Load-in-EXE tracking and sticky error; a flush never accepts, so it clears the load.
    always_comb begin
        exe_load_valid_d = exe_load_valid_q;
        exe_load_dest_d  = exe_load_dest_q;
        err_d            = err_q;
        if (!freeze) begin
            exe_load_valid_d = accept_s && issueWbEn && issueMemRead;
            exe_load_dest_d  = issueDest;
            err_d            = err_q || (|underflow_s);
        end else begin
            exe_load_valid_d = exe_load_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_load_valid_q <= 1'b0;
            exe_load_dest_q  <= '0;
            err_q            <= 1'b0;
        end else begin
            exe_load_valid_q <= exe_load_valid_d;
            exe_load_dest_q  <= exe_load_dest_d;
            err_q            <= err_d;
        end
    end

    assign hazard = hazard_s;
    assign busy   = |nz_s;
    assign err    = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       forwardEn, freeze, flush;
    logic       issueValid, issueWbEn, issueMemRead;
    logic [3:0] issueDest, src1, src2;
    logic       hasSrc1, hasSrc2, wbEn;
    logic [3:0] wbDest;
    logic       hazard, busy, err;

    int nvec;
    int nerr;

    // reference state: writes in flight per register, load in EXE, sticky error
    int m_cnt[16];
    bit m_ldv;
    int m_ldd;
    bit m_err;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .forwardEn(forwardEn), .freeze(freeze), .flush(flush),
        .issueValid(issueValid), .issueWbEn(issueWbEn), .issueMemRead(issueMemRead),
        .issueDest(issueDest), .src1(src1), .src2(src2), .hasSrc1(hasSrc1), .hasSrc2(hasSrc2),
        .wbEn(wbEn), .wbDest(wbDest), .hazard(hazard), .busy(busy), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_hazard();
        if (!issueValid) return 1'b0;
        if (issueWbEn && m_cnt[issueDest] == 3) return 1'b1;
        if (forwardEn)
            return m_ldv && ((hasSrc1 && src1 == m_ldd) || (hasSrc2 && src2 == m_ldd));
        return (hasSrc1 && m_cnt[src1] != 0) || (hasSrc2 && m_cnt[src2] != 0);
    endfunction

    function automatic bit model_busy();
        for (int r = 0; r < 16; r++) if (m_cnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_ldv = 1'b0;
        m_ldd = 0;
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit hz, acc, inc;
        hz = model_hazard();
        if (!freeze) begin
            acc = issueValid && !hz && !flush;
            inc = acc && issueWbEn;
            if (!(inc && wbEn && issueDest == wbDest)) begin
                if (inc && m_cnt[issueDest] < 3) m_cnt[issueDest]++;
                if (wbEn) begin
                    if (m_cnt[wbDest] == 0) m_err = 1'b1;
                    else m_cnt[wbDest]--;
                end
            end
            m_ldv = inc && issueMemRead;
            m_ldd = int'(issueDest);
        end
    endtask

    task automatic idle();
        forwardEn = 1'b0; freeze = 1'b0; flush = 1'b0;
        issueValid = 1'b0; issueWbEn = 1'b0; issueMemRead = 1'b0;
        issueDest = 4'd0; src1 = 4'd0; src2 = 4'd0;
        hasSrc1 = 1'b0; hasSrc2 = 1'b0; wbEn = 1'b0; wbDest = 4'd0;
    endtask

    // advance one clock with inputs held, keeping the reference model in step
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        model_reset();
        #1;
        nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL reset_state: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL reset_release: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
        @(negedge clk);
    endtask

    task automatic test_no_forward_raw();
        idle(); issueValid = 1'b1; issueWbEn = 1'b1; issueDest = 4'd3;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL raw_issue: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
        tick();
        idle(); issueValid = 1'b1; hasSrc1 = 1'b1; src1 = 4'd3;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b110) begin
            nerr++; $display("FAIL raw_stall: got hazard/busy/err=%b expected 110", {hazard, busy, err});
        end
        tick();
        wbEn = 1'b1; wbDest = 4'd3;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b110) begin
            nerr++; $display("FAIL raw_retire_cycle: got hazard/busy/err=%b expected 110", {hazard, busy, err});
        end
        tick();
        wbEn = 1'b0;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL raw_after_retire: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
        tick();
    endtask

    task automatic test_load_use();
        idle(); forwardEn = 1'b1; issueValid = 1'b1; issueWbEn = 1'b1; issueMemRead = 1'b1; issueDest = 4'd5;
        #1; tick();
        idle(); forwardEn = 1'b1; issueValid = 1'b1; hasSrc2 = 1'b1; src2 = 4'd5; src1 = 4'd5;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b110) begin
            nerr++; $display("FAIL load_use_stall: got hazard/busy/err=%b expected 110", {hazard, busy, err});
        end
        tick();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b010) begin
            nerr++; $display("FAIL load_use_one_bubble: got hazard/busy/err=%b expected 010", {hazard, busy, err});
        end
        tick();
        // non-load write to R5 retiring the load in the same cycle
        idle(); forwardEn = 1'b1; issueValid = 1'b1; issueWbEn = 1'b1; issueDest = 4'd5;
        wbEn = 1'b1; wbDest = 4'd5;
        #1; tick();
        idle(); forwardEn = 1'b1; issueValid = 1'b1; hasSrc2 = 1'b1; src2 = 4'd5;
        wbEn = 1'b1; wbDest = 4'd5;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b010) begin
            nerr++; $display("FAIL non_load_no_stall: got hazard/busy/err=%b expected 010", {hazard, busy, err});
        end
        tick();
        idle();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL load_use_drained: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
    endtask

    task automatic test_same_cycle();
        idle(); issueValid = 1'b1; issueWbEn = 1'b1; issueDest = 4'd7;
        #1; tick();
        wbEn = 1'b1; wbDest = 4'd7;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b010) begin
            nerr++; $display("FAIL same_cycle_busy: got hazard/busy/err=%b expected 010", {hazard, busy, err});
        end
        tick();
        idle(); issueValid = 1'b1; hasSrc1 = 1'b1; src1 = 4'd7; wbEn = 1'b1; wbDest = 4'd7;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b110) begin
            nerr++; $display("FAIL same_cycle_count_kept: got hazard/busy/err=%b expected 110", {hazard, busy, err});
        end
        tick();
        idle();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL same_cycle_drained: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
    endtask

    task automatic test_counter_full();
        idle(); forwardEn = 1'b1; issueValid = 1'b1; issueWbEn = 1'b1; issueDest = 4'd2;
        #1; tick(); tick(); tick();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b110) begin
            nerr++; $display("FAIL full_stall: got hazard/busy/err=%b expected 110", {hazard, busy, err});
        end
        wbEn = 1'b1; wbDest = 4'd2;
        #1; tick();
        wbEn = 1'b0;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b010) begin
            nerr++; $display("FAIL full_after_retire: got hazard/busy/err=%b expected 010", {hazard, busy, err});
        end
        tick();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b110) begin
            nerr++; $display("FAIL full_issue_accepted: got hazard/busy/err=%b expected 110", {hazard, busy, err});
        end
        idle(); wbEn = 1'b1; wbDest = 4'd2;
        #1; tick(); tick(); tick();
        idle();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL full_drained: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
    endtask

    task automatic test_random();
        logic [2:0] exp;
        int r;
        for (int i = 0; i < 600; i++) begin
            idle();
            forwardEn    = 1'($urandom_range(0, 1));
            freeze       = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            issueValid   = ($urandom_range(0, 3) != 0);
            issueWbEn    = 1'($urandom_range(0, 1));
            issueMemRead = 1'($urandom_range(0, 1));
            issueDest    = 4'($urandom_range(0, 3));
            src1         = 4'($urandom_range(0, 3));
            src2         = 4'($urandom_range(0, 3));
            hasSrc1      = 1'($urandom_range(0, 1));
            hasSrc2      = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0 && m_cnt[r] > 0) begin
                wbEn = 1'b1; wbDest = 4'(r);
            end
            #1;
            exp = {model_hazard(), model_busy(), m_err};
            nvec++;
            if ({hazard, busy, err} !== exp) begin
                nerr++; $display("FAIL random[%0d]: got hazard/busy/err=%b expected %b", i, {hazard, busy, err}, exp);
            end
            tick();
        end
        // drain whatever is left so later tests start empty
        for (int k = 0; k < 16; k++) begin
            while (m_cnt[k] > 0) begin
                idle(); wbEn = 1'b1; wbDest = 4'(k);
                #1; tick();
            end
        end
        idle();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL random_drained: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
    endtask

    task automatic test_err_freeze();
        idle(); wbEn = 1'b1; wbDest = 4'd9;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL err_before: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
        tick();
        idle();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b001) begin
            nerr++; $display("FAIL err_set: got hazard/busy/err=%b expected 001", {hazard, busy, err});
        end
        tick();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b001) begin
            nerr++; $display("FAIL err_sticky: got hazard/busy/err=%b expected 001", {hazard, busy, err});
        end
        freeze = 1'b1; issueValid = 1'b1; issueWbEn = 1'b1; issueDest = 4'd4;
        #1; tick();
        idle(); issueValid = 1'b1; hasSrc1 = 1'b1; src1 = 4'd4;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b001) begin
            nerr++; $display("FAIL freeze_no_count: got hazard/busy/err=%b expected 001", {hazard, busy, err});
        end
        tick();
    endtask

    task automatic test_async_reset();
        idle(); issueValid = 1'b1; issueWbEn = 1'b1; issueDest = 4'd1;
        #1; tick();
        idle(); issueValid = 1'b1; hasSrc1 = 1'b1; src1 = 4'd1;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b111) begin
            nerr++; $display("FAIL async_pre: got hazard/busy/err=%b expected 111", {hazard, busy, err});
        end
        #1 rst = 1'b0;
        model_reset();
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL async_reset_immediate: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
        @(negedge clk);
        rst = 1'b1;
        #1; nvec++;
        if ({hazard, busy, err} !== 3'b000) begin
            nerr++; $display("FAIL async_reset_released: got hazard/busy/err=%b expected 000", {hazard, busy, err});
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_no_forward_raw();
        test_load_use();
        test_same_cycle();
        test_counter_full();
        test_random();
        test_err_freeze();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: the single pipeline clock; all state updates on its rising edge.
REQ-003 Port `rst`, input, 1 bit: asynchronous reset, active-low (0 = reset).
REQ-004 Port `forwardEn`, input, 1 bit: forwarding unit enabled; selects the hazard rule.
REQ-005 Port `freeze`, input, 1 bit: memory stage busy; whole pipeline held this cycle.
REQ-006 Port `flush`, input, 1 bit: taken branch; the ID-stage instruction is squashed this cycle.
REQ-007 Port `issueValid`, input, 1 bit: an ID-stage instruction is present.
REQ-008 Port `issueWbEn`, input, 1 bit: that instruction writes a register.
REQ-009 Port `issueMemRead`, input, 1 bit: that instruction is a load.
REQ-010 Port `issueDest`, input, 4 bits: destination register of the ID-stage instruction.
REQ-011 Port `src1`, input, 4 bits: first source register of the ID-stage instruction.
REQ-012 Port `src2`, input, 4 bits: second source register of the ID-stage instruction.
REQ-013 Port `hasSrc1`, input, 1 bit: `src1` is read by the instruction.
REQ-014 Port `hasSrc2`, input, 1 bit: `src2` is read by the instruction.
REQ-015 Port `wbEn`, input, 1 bit: the WB stage writes `wbDest` this cycle.
REQ-016 Port `wbDest`, input, 4 bits: register being written back.
REQ-017 Port `hazard`, output, 1 bit: stall IF/ID and inject a bubble into EXE.
REQ-018 Port `busy`, output, 1 bit: at least one write is in flight.
REQ-019 Port `err`, output, 1 bit: sticky flag for a retire with no matching issue.

Function
REQ-020 State SHALL be 16 pending counters `cnt[r]` (2-bit, 0..3), plus `exeLoadValid` (1 bit) and `exeLoadDest` (4 bits).
REQ-021 Accept SHALL be true when `issueValid && !hazard && !freeze && !flush`.
REQ-022 On accept with `issueWbEn`, `cnt[issueDest]` SHALL increment; the increment is visible to `hazard` the next cycle.
REQ-023 When `wbEn && !freeze`, `cnt[wbDest]` SHALL decrement.
REQ-024 Increment and decrement of the same register in one cycle SHALL leave the count unchanged; different registers SHALL update independently.
REQ-025 A decrement at count 0 SHALL leave the count at 0 and set `err`; `err` clears only on reset.
REQ-026 On a non-frozen cycle, `exeLoadValid` SHALL load `accept && issueWbEn && issueMemRead`, and `exeLoadDest` SHALL load `issueDest`.
REQ-027 `flush` SHALL clear `exeLoadValid` on a non-frozen cycle.
REQ-028 While `freeze=1`, all state SHALL hold, including `cnt`, `exeLoadValid` and `err`.
REQ-029 With `forwardEn=0`, `hazard` SHALL be 1 iff `issueValid` and a used source (`hasSrcN`) has `cnt[srcN]!=0`.
REQ-030 With `forwardEn=1`, `hazard` SHALL be 1 iff `issueValid && exeLoadValid` and a used source equals `exeLoadDest` (load-use, one bubble).
REQ-031 In either mode, `hazard` SHALL also be 1 when `issueValid && issueWbEn && cnt[issueDest]==3` (counter full).
REQ-032 `hazard` SHALL be combinational from current state and inputs and SHALL NOT depend on `freeze` or `flush`.
REQ-033 `busy` SHALL equal the OR of `cnt[r]!=0` over all r.

Reset
REQ-034 While `rst=0`, all `cnt`, `exeLoadValid`, `exeLoadDest` and `err` SHALL be 0 immediately, without waiting for a clock.
REQ-035 With state at reset values, `hazard` SHALL be 0 unless `cnt` is full (which cannot occur from reset), and `busy` SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight tracking; the pipeline is reset together with this block.

Structure
REQ-037 The shared pipeline package SHALL hold the register-index width (4), the register count (16) and the counter width (2).
REQ-038 The block SHALL contain one sub-module, `pending_counter`: a 2-bit saturating up/down counter with hold and error output, instantiated 16 times.

Verification
REQ-039 `forwardEn=0`: issue R3 write, next cycle src1=R3 -> `hazard=1` until the R3 retire, and 0 in the cycle after that retire.
REQ-040 `forwardEn=1`: load to R5, next cycle src2=R5 with `hasSrc2=1` -> `hazard=1` exactly one cycle; a non-load to R5 -> `hazard=0`.
REQ-041 Issue to R7 and retire R7 in the same cycle with `cnt[7]=1` -> `cnt[7]` stays 1 and `busy` stays 1.
REQ-042 Three writes to R2 outstanding, a fourth issue to R2 -> `hazard=1`; after one R2 retire -> `hazard=0` and the issue is accepted.
REQ-043 `wbEn=1`, `wbDest=R9` with `cnt[9]=0` -> `err=1` persisting; `freeze=1` during an issue -> no count change.
REQ-044 Drive `rst=0` between clock edges with `busy=1` -> `busy=0`, `hazard=0` and `err=0` at once.
